// File: rtl/reduce_gates_seq.sv
// reduce_gates_seq: multi-cycle AND/NAND/OR/NOR/XOR/popcount reduction over a val/rdy handshake
module reduce_gates_seq #(
    parameter  int NBITS  = 100,
    parameter  int CHUNK  = 16,
    localparam int NCHUNK = (NBITS + CHUNK - 1) / CHUNK,
    localparam int CW     = $clog2(NBITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             out_and,
    output logic             out_nand,
    output logic             out_or,
    output logic             out_nor,
    output logic             out_xor,
    output logic [CW-1:0]    out_popcount
);
    localparam int PW = NCHUNK * CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    // Marks real operand bits; bits above NBITS in the last chunk are padding.
    localparam logic [PW-1:0] MASK = {PW{1'b1}} >> (PW - NBITS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             and_q, and_d, or_q, or_d, xor_q, xor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             res_and_q, res_and_d, res_or_q, res_or_d, res_xor_q, res_xor_d;
    logic [CW-1:0]    res_cnt_q, res_cnt_d;
    logic [PW-1:0]    pad;
    logic [CHUNK-1:0] bits, valid;
    logic [CW-1:0]    chunk_cnt, n_cnt;
    logic             n_and, n_or, n_xor;

    // Slice out the current chunk and fold it into the running accumulators.
    always_comb begin
        pad       = PW'(data_q);
        bits      = CHUNK'(pad >> (int'(idx_q) * CHUNK));
        valid     = CHUNK'(MASK >> (int'(idx_q) * CHUNK));
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) chunk_cnt = chunk_cnt + CW'(bits[i]);
        n_and     = and_q & (&(bits | ~valid));
        n_or      = or_q | (|bits);
        n_xor     = xor_q ^ (^bits);
        n_cnt     = cnt_q + chunk_cnt;
    end

    // Next-state logic: accept in IDLE, scan in BUSY, hold the result in DONE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        and_d     = and_q;
        or_d      = or_q;
        xor_d     = xor_q;
        cnt_d     = cnt_q;
        res_and_d = res_and_q;
        res_or_d  = res_or_q;
        res_xor_d = res_xor_q;
        res_cnt_d = res_cnt_q;
        unique case (state_q)
            IDLE: if (in_val) begin
                state_d = BUSY;
                data_d  = in_;
                idx_d   = '0;
                and_d   = 1'b1;
                or_d    = 1'b0;
                xor_d   = 1'b0;
                cnt_d   = '0;
            end
            BUSY: begin
                and_d = n_and;
                or_d  = n_or;
                xor_d = n_xor;
                cnt_d = n_cnt;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NCHUNK - 1)) begin
                    state_d   = DONE;
                    idx_d     = '0;
                    res_and_d = n_and;
                    res_or_d  = n_or;
                    res_xor_d = n_xor;
                    res_cnt_d = n_cnt;
                end
            end
            DONE: state_d = out_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            and_q     <= 1'b1;
            or_q      <= 1'b0;
            xor_q     <= 1'b0;
            cnt_q     <= '0;
            res_and_q <= 1'b0;
            res_or_q  <= 1'b0;
            res_xor_q <= 1'b0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            and_q     <= and_d;
            or_q      <= or_d;
            xor_q     <= xor_d;
            cnt_q     <= cnt_d;
            res_and_q <= res_and_d;
            res_or_q  <= res_or_d;
            res_xor_q <= res_xor_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign in_rdy       = state_q == IDLE;
    assign out_val      = state_q == DONE;
    assign out_and      = res_and_q;
    assign out_nand     = ~res_and_q;
    assign out_or       = res_or_q;
    assign out_nor      = ~res_or_q;
    assign out_xor      = res_xor_q;
    assign out_popcount = res_cnt_q;
endmodule

// File: tb/tb_reduce_gates_seq.sv
// tb_reduce_gates_seq: directed and parameter-sweep checks of reduce_gates_seq with a scoreboard
module tb_reduce_gates_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    typedef struct {logic a; logic o; logic x; int c;} exp_t;
    exp_t sb_m[$], sb1[$], sb2[$], sb3[$];
    int checks = 0, errors = 0;

    logic        m_val = 1'b0, m_rdy = 1'b0;
    logic [99:0] m_in = '0;
    logic        m_in_rdy, m_oval, m_and, m_nand, m_or, m_nor, m_xor;
    logic [6:0]  m_cnt;

    logic        sw_val = 1'b0, sw_rdy = 1'b0;
    logic [99:0] sw_in = '0;
    logic        s1_ir, s1_ov, s1_a, s1_na, s1_o, s1_no, s1_x;
    logic [6:0]  s1_c;
    logic        s2_ir, s2_ov, s2_a, s2_na, s2_o, s2_no, s2_x;
    logic [6:0]  s2_c;
    logic        s3_ir, s3_ov, s3_a, s3_na, s3_o, s3_no, s3_x;
    logic [0:0]  s3_c;

    reduce_gates_seq dut (
        .clk(clk), .reset(reset), .in_val(m_val), .in_rdy(m_in_rdy), .in_(m_in),
        .out_val(m_oval), .out_rdy(m_rdy), .out_and(m_and), .out_nand(m_nand),
        .out_or(m_or), .out_nor(m_nor), .out_xor(m_xor), .out_popcount(m_cnt));

    reduce_gates_seq #(.NBITS(100), .CHUNK(1)) dut_c1 (
        .clk(clk), .reset(reset), .in_val(sw_val), .in_rdy(s1_ir), .in_(sw_in),
        .out_val(s1_ov), .out_rdy(sw_rdy), .out_and(s1_a), .out_nand(s1_na),
        .out_or(s1_o), .out_nor(s1_no), .out_xor(s1_x), .out_popcount(s1_c));

    reduce_gates_seq #(.NBITS(100), .CHUNK(100)) dut_c100 (
        .clk(clk), .reset(reset), .in_val(sw_val), .in_rdy(s2_ir), .in_(sw_in),
        .out_val(s2_ov), .out_rdy(sw_rdy), .out_and(s2_a), .out_nand(s2_na),
        .out_or(s2_o), .out_nor(s2_no), .out_xor(s2_x), .out_popcount(s2_c));

    reduce_gates_seq #(.NBITS(1), .CHUNK(1)) dut_n1 (
        .clk(clk), .reset(reset), .in_val(sw_val), .in_rdy(s3_ir), .in_(sw_in[0:0]),
        .out_val(s3_ov), .out_rdy(sw_rdy), .out_and(s3_a), .out_nand(s3_na),
        .out_or(s3_o), .out_nor(s3_no), .out_xor(s3_x), .out_popcount(s3_c));

    function automatic exp_t model(logic [99:0] v, int n);
        exp_t e;
        e.a = 1'b1; e.o = 1'b0; e.x = 1'b0; e.c = 0;
        for (int i = 0; i < n; i++) begin
            e.a = e.a & v[i];
            e.o = e.o | v[i];
            e.x = e.x ^ v[i];
            e.c = e.c + int'(v[i]);
        end
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(string tag, exp_t e, logic a, logic na, logic o, logic no,
                             logic x, logic [31:0] c);
        check({tag, " and"}, 32'(a), 32'(e.a));
        check({tag, " nand"}, 32'(na), 32'(!e.a));
        check({tag, " or"}, 32'(o), 32'(e.o));
        check({tag, " nor"}, 32'(no), 32'(!e.o));
        check({tag, " xor"}, 32'(x), 32'(e.x));
        check({tag, " popcount"}, c, 32'(e.c));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_main(string tag, logic [99:0] v);
        int lat;
        exp_t e;
        m_in = v;
        m_val = 1'b1;
        sb_m.push_back(model(v, 100));
        step;
        m_val = 1'b0;
        lat = 0;
        while (!m_oval && lat < 50) begin
            step;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd7);
        e = sb_m.pop_front();
        check_res(tag, e, m_and, m_nand, m_or, m_nor, m_xor, 32'(m_cnt));
    endtask

    task automatic release_main(string tag);
        m_rdy = 1'b1;
        step;
        m_rdy = 1'b0;
        check({tag, " idle in_rdy"}, 32'(m_in_rdy), 32'd1);
        check({tag, " idle out_val"}, 32'(m_oval), 32'd0);
    endtask

    initial begin
        exp_t e, rst_e;
        int l1, l2, l3, cyc;
        rst_e = '{a: 1'b0, o: 1'b0, x: 1'b0, c: 0};
        #2 reset = 1'b0;
        step;
        step;
        check("reset in_rdy", 32'(m_in_rdy), 32'd1);
        check("reset out_val", 32'(m_oval), 32'd0);
        check_res("reset", rst_e, m_and, m_nand, m_or, m_nor, m_xor, 32'(m_cnt));
        reset = 1'b1;
        step;

        run_main("zero", 100'h0);
        release_main("zero");
        run_main("ones", 100'hf_ffff_ffff_ffff_ffff_ffff_ffff);
        release_main("ones");
        run_main("topbit", 100'h8_0000_0000_0000_0000_0000_0000);

        e = model(100'h8_0000_0000_0000_0000_0000_0000, 100);
        m_val = 1'b1;
        m_in = 100'hf_ffff_ffff_ffff_ffff_ffff_ffff;
        for (int k = 0; k < 5; k++) begin
            step;
            check("bp in_rdy", 32'(m_in_rdy), 32'd0);
            check("bp out_val", 32'(m_oval), 32'd1);
            check_res("bp", e, m_and, m_nand, m_or, m_nor, m_xor, 32'(m_cnt));
        end
        m_val = 1'b0;
        release_main("bp");
        step;
        check("bp stays idle", 32'(m_in_rdy), 32'd1);

        run_main("pattern", 100'h0_1234_1234_1234_1234_1234_1234);
        release_main("pattern");

        m_in = 100'hf_ffff_ffff_ffff_ffff_ffff_ffff;
        m_val = 1'b1;
        sb_m.push_back(model(m_in, 100));
        step;
        m_val = 1'b0;
        step;
        step;
        step;
        reset = 1'b0;
        #1;
        void'(sb_m.pop_back());
        check("abort out_val", 32'(m_oval), 32'd0);
        check("abort in_rdy", 32'(m_in_rdy), 32'd1);
        check_res("abort", rst_e, m_and, m_nand, m_or, m_nor, m_xor, 32'(m_cnt));
        step;
        reset = 1'b1;
        step;
        check("abort no result", 32'(m_oval), 32'd0);
        run_main("after_rst", 100'hf_ffff_ffff_ffff_ffff_ffff_fffe);
        release_main("after_rst");

        for (int k = 0; k < 20; k++) begin
            sw_in = 100'({$urandom(), $urandom(), $urandom(), $urandom()});
            sb1.push_back(model(sw_in, 100));
            sb2.push_back(model(sw_in, 100));
            sb3.push_back(model(sw_in, 1));
            sw_val = 1'b1;
            step;
            sw_val = 1'b0;
            l1 = -1; l2 = -1; l3 = -1; cyc = 0;
            while ((l1 < 0 || l2 < 0 || l3 < 0) && cyc < 150) begin
                step;
                cyc++;
                if (s1_ov && l1 < 0) l1 = cyc;
                if (s2_ov && l2 < 0) l2 = cyc;
                if (s3_ov && l3 < 0) l3 = cyc;
            end
            check("c1 latency", 32'(l1), 32'd100);
            check("c100 latency", 32'(l2), 32'd1);
            check("n1 latency", 32'(l3), 32'd1);
            e = sb1.pop_front();
            check_res("c1", e, s1_a, s1_na, s1_o, s1_no, s1_x, 32'(s1_c));
            e = sb2.pop_front();
            check_res("c100", e, s2_a, s2_na, s2_o, s2_no, s2_x, 32'(s2_c));
            e = sb3.pop_front();
            check_res("n1", e, s3_a, s3_na, s3_o, s3_no, s3_x, 32'(s3_c));
            sw_rdy = 1'b1;
            step;
            sw_rdy = 1'b0;
            check("sweep idle", 32'({s1_ir, s2_ir, s3_ir}), 32'b111);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
